// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the IFU/LSU memory arbiter:
//   - state_t : arbiter FSM states (IDLE / REQ / WAIT)
//   - owner_t : transaction owner encoding (OWN_IFU=0, OWN_LSU=1)
//   - TIMEOUT_DEFAULT : default response timeout in WAIT cycles
package mem_arbiter_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin grant between IFU and LSU.
//   Ports:
//     i_valid_ifu  - IFU request valid
//     i_valid_lsu  - LSU request valid
//     i_last_grant - owner that received the previous grant
//     o_grant      - some requester is granted this cycle
//     o_owner      - which requester is granted (valid when o_grant=1)
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic   i_valid_ifu,
  input  logic   i_valid_lsu,
  input  owner_t i_last_grant,
  output logic   o_grant,
  output owner_t o_owner
);

  always_comb begin
    o_grant = i_valid_ifu | i_valid_lsu;
    if (i_valid_ifu && i_valid_lsu) begin
      // Contention: hand the grant to whoever did not get the last one.
      o_owner = (i_last_grant == OWN_IFU) ? OWN_LSU : OWN_IFU;
    end else if (i_valid_lsu) begin
      o_owner = OWN_LSU;
    end else begin
      o_owner = OWN_IFU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates an instruction-fetch port (IFU, read-only) and a load/store
//   port (LSU) onto a single memory port with one outstanding transaction.
//   IDLE grants (round-robin on contention), REQ presents the registered
//   request until mem_req_ready, WAIT returns mem_resp_valid/mem_rdata to the
//   owner in the same cycle or aborts after TIMEOUT WAIT cycles.
//   Ports:
//     clk, rst          - clock (rising edge), synchronous active-high reset
//     ifu_req_*/resp_*  - fetch request/response
//     lsu_req_*/resp_*  - load/store request/response (stores complete too)
//     mem_req_*/resp_*  - shared memory port
//     err_timeout       - one-cycle pulse when a response times out
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_timeout
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t              r_state;
  owner_t              r_owner;
  owner_t              r_last_grant;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;

  logic                w_grant;
  owner_t              w_grant_owner;
  logic                w_cnt_max;
  logic                w_resp_hit;
  logic                w_timeout;
  logic                w_done;

  rr_arb2 u_rr_arb2 (
    .i_valid_ifu  (ifu_req_valid),
    .i_valid_lsu  (lsu_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_owner      (w_grant_owner)
  );

  assign w_cnt_max = (r_wait_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= OWN_IFU;
      r_last_grant <= OWN_LSU;
      r_wait_cnt   <= '0;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner      <= w_grant_owner;
            r_last_grant <= w_grant_owner;
            if (w_grant_owner == OWN_LSU) begin
              r_addr  <= lsu_addr;
              r_wen   <= lsu_wen;
              r_wdata <= lsu_wdata;
              r_wmask <= lsu_wmask;
            end else begin
              r_addr  <= ifu_addr;
              r_wen   <= 1'b0;
              r_wdata <= '0;
              r_wmask <= '0;
            end
            r_state <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_wait_cnt <= '0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid || w_cnt_max) begin
            r_state <= IDLE;
          end
          if (!w_cnt_max) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Response path is combinational from mem_resp_valid; rst masks it so a
  // transaction abandoned by reset never delivers a response.
  always_comb begin
    w_resp_hit = !rst && (r_state == WAIT) && mem_resp_valid;
    w_timeout  = !rst && (r_state == WAIT) && !mem_resp_valid && w_cnt_max;
    w_done     = w_resp_hit || w_timeout;

    ifu_req_ready  = !rst && (r_state == IDLE) && w_grant && (w_grant_owner == OWN_IFU);
    lsu_req_ready  = !rst && (r_state == IDLE) && w_grant && (w_grant_owner == OWN_LSU);

    ifu_resp_valid = w_done && (r_owner == OWN_IFU);
    lsu_resp_valid = w_done && (r_owner == OWN_LSU);
    ifu_rdata      = (w_resp_hit && (r_owner == OWN_IFU)) ? mem_rdata : '0;
    lsu_rdata      = (w_resp_hit && (r_owner == OWN_LSU)) ? mem_rdata : '0;

    mem_req_valid  = !rst && (r_state == REQ);
    mem_addr       = r_addr;
    mem_wen        = r_wen;
    mem_wdata      = r_wdata;
    mem_wmask      = r_wmask;

    err_timeout    = w_timeout;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter: each request pushes its expected memory
//   fields and response; a negedge monitor checks mem_* while the request is
//   presented and pops/compares when a response appears.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW / 8;
  localparam int unsigned TO = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [DW-1:0] lsu_wdata;
  logic [MW-1:0] lsu_wmask;
  logic          lsu_resp_valid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_rdata;
  logic          err_timeout;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .err_timeout    (err_timeout)
  );

  typedef struct {
    bit          lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    bit          to;
    int unsigned wait_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // memory-side configuration, written by the stimulus process
  int unsigned cfg_delay    = 0;
  bit          cfg_no_resp  = 1'b0;
  int unsigned stall_left   = 0;
  bit          inject_stale = 1'b0;
  bit          m_last       = 1'b1;  // model of last_grant (1 = LSU)

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // memory responder
  bit          rsp_pend = 1'b0;
  int unsigned rsp_cnt  = 0;
  logic [31:0] rsp_addr = '0;

  initial begin
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_pend = 1'b0;
      end else if (mem_req_valid && mem_req_ready) begin
        rsp_pend = !cfg_no_resp;
        rsp_cnt  = cfg_delay;
        rsp_addr = mem_addr;
      end else if (mem_req_valid && !mem_req_ready && stall_left > 0) begin
        stall_left--;
      end
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      mem_rdata      = $urandom;
      if (inject_stale) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hBAD0_0BAD;
        inject_stale   = 1'b0;
      end else if (rsp_pend) begin
        if (rsp_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_rdata      = mem_model(rsp_addr);
          rsp_pend       = 1'b0;
        end else begin
          rsp_cnt--;
        end
      end
      mem_req_ready = (stall_left == 0);
    end
  end

  // monitor
  bit          in_wait = 1'b0;
  int unsigned wcnt    = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_wait = 1'b0;
    end else begin
      if (in_wait) wcnt++;
      if (mem_req_valid) begin
        if (sb.size() == 0) begin
          check_eq("req_unexpected", 1, 0);
        end else begin
          check_eq("mem_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask},
                   {sb[0].addr, sb[0].wen, sb[0].wdata, sb[0].wmask});
        end
        if (mem_req_ready) begin
          in_wait = 1'b1;
          wcnt    = 0;
        end
      end
      if (ifu_resp_valid || lsu_resp_valid) begin
        if (sb.size() == 0) begin
          check_eq("resp_unexpected", {ifu_resp_valid, lsu_resp_valid}, 0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("resp_owner", {ifu_resp_valid, lsu_resp_valid}, mon_e.lsu ? 2'b01 : 2'b10);
          check_eq("resp_rdata", mon_e.lsu ? lsu_rdata : ifu_rdata, mon_e.rdata);
          check_eq("nonowner_rdata", mon_e.lsu ? ifu_rdata : lsu_rdata, 0);
          check_eq("resp_err", err_timeout, mon_e.to);
          check_eq("wait_cycles", wcnt, mon_e.wait_cyc);
          check_eq("no_grant_on_resp", {ifu_req_ready, lsu_req_ready}, 0);
        end
        in_wait = 1'b0;
      end else if (err_timeout) begin
        check_eq("err_without_resp", 1, 0);
      end
    end
  end

  task automatic run_reqs(input bit use_ifu, input bit use_lsu, input int n,
                          input logic [31:0] ifu_base, input logic [31:0] lsu_base,
                          input logic l_wen, input logic [31:0] l_wdata, input logic [3:0] l_wmask);
    int   ki = 0;
    int   kl = 0;
    int   since = 0;
    bit   own;
    bit   order[$];
    exp_t e;
    for (int i = 0; i < n; i++) begin
      own    = (use_ifu && use_lsu) ? !m_last : use_lsu;
      m_last = own;
      e.lsu  = own;
      if (own) begin
        e.addr = lsu_base + 32'(4 * kl); e.wen = l_wen; e.wdata = l_wdata; e.wmask = l_wmask;
        kl++;
      end else begin
        e.addr = ifu_base + 32'(4 * ki); e.wen = 1'b0; e.wdata = '0; e.wmask = '0;
        ki++;
      end
      e.to       = cfg_no_resp || (cfg_delay > TO);
      e.rdata    = e.to ? 32'h0 : mem_model(e.addr);
      e.wait_cyc = e.to ? TO + 1 : cfg_delay + 1;
      sb.push_back(e);
      order.push_back(own);
    end
    ki = 0;
    kl = 0;
    ifu_addr = ifu_base;
    lsu_addr = lsu_base;
    lsu_wen = l_wen; lsu_wdata = l_wdata; lsu_wmask = l_wmask;
    ifu_req_valid = use_ifu;
    lsu_req_valid = use_lsu;
    for (int i = 0; i < n; i++) begin
      int budget = 2000;
      bit got = 1'b0;
      while (!got && budget > 0) begin
        @(negedge clk);
        since++;
        if (ifu_req_ready || lsu_req_ready) begin
          got = 1'b1;
          check_eq("grant", {ifu_req_ready, lsu_req_ready}, order[i] ? 2'b01 : 2'b10);
          if (i > 0) check_eq("spacing", since, 3 + cfg_delay);
          since = 0;
        end
        budget--;
        @(posedge clk);
        #1;
        if (got) begin
          if (order[i]) begin kl++; lsu_addr = lsu_base + 32'(4 * kl); end
          else          begin ki++; ifu_addr = ifu_base + 32'(4 * ki); end
        end
      end
      if (!got) begin
        check_eq("grant_wait", 0, 1);
        break;
      end
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check_eq("drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_addr = '0;
    lsu_req_valid = 1'b0;
    lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    cycles(2);
    @(negedge clk);
    check_eq("reset_flags", {ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid,
                             mem_req_valid, mem_wen, err_timeout}, 0);
    check_eq("reset_rdata", {ifu_rdata, lsu_rdata}, 0);
    check_eq("reset_mem", {mem_addr, mem_wdata, mem_wmask}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifu_req_valid = 1'b0;
    m_last = 1'b1;

    // both valid after reset: IFU, LSU, IFU, LSU
    cfg_delay = 0;
    run_reqs(1'b1, 1'b1, 4, 32'h8000_0100, 32'h8000_2000, 1'b0, 32'h0, 4'h0);
    drain(50);

    // single IFU fetch, response two cycles after the first WAIT cycle
    cfg_delay = 2;
    run_reqs(1'b1, 1'b0, 1, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0);
    drain(50);

    // LSU store with three stalled REQ cycles
    cfg_delay = 1;
    stall_left = 3;
    run_reqs(1'b0, 1'b1, 1, 32'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    drain(50);

    // response lands exactly on the timeout cycle: response wins, no error
    cfg_delay = TO;
    run_reqs(1'b0, 1'b1, 1, 32'h0, 32'h8000_3000, 1'b0, 32'h0, 4'h0);
    drain(400);

    // no response at all: timeout abort to IFU
    cfg_delay = 0;
    cfg_no_resp = 1'b1;
    run_reqs(1'b1, 1'b0, 1, 32'h8000_0040, 32'h0, 1'b0, 32'h0, 4'h0);
    drain(400);

    // reset while in WAIT, then a stale response
    run_reqs(1'b1, 1'b0, 1, 32'h8000_0080, 32'h0, 1'b0, 32'h0, 4'h0);
    cycles(3);
    rst = 1'b1;
    sb.delete();
    m_last = 1'b1;
    cfg_no_resp = 1'b0;
    @(negedge clk);
    check_eq("rst_in_wait", {ifu_resp_valid, lsu_resp_valid, mem_req_valid, err_timeout}, 0);
    inject_stale = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("stale_ignored", {ifu_resp_valid, lsu_resp_valid, err_timeout, ifu_rdata, lsu_rdata}, 0);
    @(posedge clk);
    #1;
    cfg_delay = 1;
    run_reqs(1'b1, 1'b0, 1, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0);
    drain(50);
    run_reqs(1'b1, 1'b1, 2, 32'h8000_0200, 32'h8000_4000, 1'b1, 32'h1234_5678, 4'h3);
    drain(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
